// File: rtl/rf_write_port_pkg.sv
// Shared constants and types for the register-file read and write paths.
// The read mux imports the same NUM_REGS / RF_BASE_HI so both sides agree on the address map.
package rf_pkg;
  localparam int NUM_REGS = 23;
  localparam logic [7:0] RF_BASE_HI = 8'h01;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {IDLE, DECODE, WRITE, RESP} rf_wr_state_t;
  typedef logic [4:0] rf_idx_t;

  // Low address byte is BCD: tens nibble in [7:4], units nibble in [3:0].
  function automatic rf_idx_t bcd_to_idx(input logic [7:0] b);
    return rf_idx_t'({3'b000, b[5:4]} * 5'd10 + {1'b0, b[3:0]});
  endfunction
endpackage

// File: rtl/rf_write_port_if.sv
// Write request channel between a bus master and rf_write_port.
// Handshake: the master raises req with Addr/Din and holds req until it sees the one-cycle
// ack pulse, dropping req in that same cycle; err is meaningful only while ack is high.
interface rf_write_port_if;
  import rf_pkg::*;

  logic                req;
  logic [ADDR_W-1:0]   Addr;
  logic [DATA_W-1:0]   Din;
  logic [DATA_W-1:0]   to_reg;
  logic [NUM_REGS-1:0] we;
  logic                ack;
  logic                err;
  logic                busy;

  modport master (
    output req, Addr, Din,
    input  to_reg, we, ack, err, busy
  );

  modport slave (
    input  req, Addr, Din,
    output to_reg, we, ack, err, busy
  );
endinterface

// File: rtl/rf_write_port_addr_decode.sv
// Combinational address check and index extraction for the 23-entry register file.
// With RF_WRITE_PROTECT_EN defined, reg0 (0x0100) is reported as not writable.
module rf_addr_decode
  import rf_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  output rf_idx_t           o_idx,
  output logic              o_valid
);
  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic       w_in_map;

  assign w_tens  = i_addr[7:4];
  assign w_units = i_addr[3:0];
  assign o_idx   = bcd_to_idx(i_addr[7:0]);

  // 00-09 and 10-19 take any BCD units digit; the 2x row stops at 22.
  assign w_in_map = (i_addr[15:8] == RF_BASE_HI) &&
                    (w_tens <= 4'd2) && (w_units <= 4'd9) &&
                    ((w_tens != 4'd2) || (w_units <= 4'd2));

`ifdef RF_WRITE_PROTECT_EN
  assign o_valid = w_in_map && (o_idx != rf_idx_t'(0));
`else
  assign o_valid = w_in_map;
`endif
endmodule

// File: rtl/rf_write_port.sv
// Register-file write port: latches one request, decodes it, pulses a one-hot we, then acks.
// Optional build macro RF_WRITE_PROTECT_EN makes reg0 read-only (see rf_addr_decode).
module rf_write_port
  import rf_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  rf_write_port_if.slave bus,
  output rf_wr_state_t   o_dbg_state
);
  rf_wr_state_t        r_state;
  rf_wr_state_t        w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_to_reg;
  rf_idx_t             r_idx;
  logic                r_err;
  rf_idx_t             w_idx;
  logic                w_valid;
  logic [NUM_REGS-1:0] w_we;
  logic                w_ack;
  logic                w_err;
  logic                w_busy;

  rf_addr_decode u_dec (
    .i_addr  (r_addr),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req) w_next = DECODE;
      DECODE:  w_next = w_valid ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Only the latched address feeds the decoder, so Addr/Din churn while busy has no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_din    <= '0;
      r_to_reg <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_addr <= bus.Addr;
            r_din  <= bus.Din;
            r_err  <= 1'b0;
          end
        end
        DECODE: begin
          r_idx <= w_idx;
          r_err <= !w_valid;
          if (w_valid) r_to_reg <= r_din;
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by reset so nothing is written or acknowledged while it is held.
  always_comb begin
    w_we   = '0;
    w_ack  = 1'b0;
    w_err  = 1'b0;
    w_busy = (r_state != IDLE);
    if (r_state == WRITE && !reset) begin
      for (int i = 0; i < NUM_REGS; i++) w_we[i] = (r_idx == rf_idx_t'(i));
    end
    if (r_state == RESP && !reset) begin
      w_ack = 1'b1;
      w_err = r_err;
    end
  end

  assign bus.to_reg  = r_to_reg;
  assign bus.we      = w_we;
  assign bus.ack     = w_ack;
  assign bus.err     = w_err;
  assign bus.busy    = w_busy;
  assign o_dbg_state = r_state;
endmodule
